// File: rtl/scarv_integ_axi_arb2.sv
// Two-master to one-slave AXI4-lite arbiter: one outstanding transaction, round-robin
// grants, writes ahead of reads. Slave-side valids depend only on state, flags and master valids.
module scarv_integ_axi_arb2 #(
   parameter int ADDR_W = 32
) (
   input  logic              g_clk,
   input  logic              g_reset,

   input  logic              m0_awvalid,
   output logic              m0_awready,
   input  logic [ADDR_W-1:0] m0_awaddr,
   input  logic [2:0]        m0_awprot,
   input  logic              m0_wvalid,
   output logic              m0_wready,
   input  logic [31:0]       m0_wdata,
   input  logic [3:0]        m0_wstrb,
   output logic              m0_bvalid,
   input  logic              m0_bready,
   input  logic              m0_arvalid,
   output logic              m0_arready,
   input  logic [ADDR_W-1:0] m0_araddr,
   input  logic [2:0]        m0_arprot,
   output logic              m0_rvalid,
   input  logic              m0_rready,
   output logic [31:0]       m0_rdata,

   input  logic              m1_awvalid,
   output logic              m1_awready,
   input  logic [ADDR_W-1:0] m1_awaddr,
   input  logic [2:0]        m1_awprot,
   input  logic              m1_wvalid,
   output logic              m1_wready,
   input  logic [31:0]       m1_wdata,
   input  logic [3:0]        m1_wstrb,
   output logic              m1_bvalid,
   input  logic              m1_bready,
   input  logic              m1_arvalid,
   output logic              m1_arready,
   input  logic [ADDR_W-1:0] m1_araddr,
   input  logic [2:0]        m1_arprot,
   output logic              m1_rvalid,
   input  logic              m1_rready,
   output logic [31:0]       m1_rdata,

   output logic              s_awvalid,
   input  logic              s_awready,
   output logic [ADDR_W-1:0] s_awaddr,
   output logic [2:0]        s_awprot,
   output logic              s_wvalid,
   input  logic              s_wready,
   output logic [31:0]       s_wdata,
   output logic [3:0]        s_wstrb,
   input  logic              s_bvalid,
   output logic              s_bready,
   output logic              s_arvalid,
   input  logic              s_arready,
   output logic [ADDR_W-1:0] s_araddr,
   output logic [2:0]        s_arprot,
   input  logic              s_rvalid,
   output logic              s_rready,
   input  logic [31:0]       s_rdata,

   output logic              grant_id,
   output logic              busy,
   output logic [2:0]        o_dbg_state
);

   // Handshake rule on every channel: a beat transfers on a rising edge where valid and
   // ready are both high; valid, once raised, is never made to depend on ready.
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_WR   = 3'd1,
      ST_WB   = 3'd2,
      ST_RD   = 3'd3,
      ST_RR   = 3'd4
   } state_t;

   state_t r_state;
   logic   r_grant;
   logic   r_last_grant;
   logic   r_aw_done;
   logic   r_w_done;

   logic              w_req0, w_req1, w_win, w_win_wr;
   logic              w_in_wr, w_in_wb, w_in_rd, w_in_rr;
   logic              w_to_m0, w_to_m1;
   logic              w_sel_awvalid, w_sel_wvalid, w_sel_bready, w_sel_arvalid, w_sel_rready;
   logic [ADDR_W-1:0] w_sel_awaddr, w_sel_araddr;
   logic [2:0]        w_sel_awprot, w_sel_arprot;
   logic [31:0]       w_sel_wdata;
   logic [3:0]        w_sel_wstrb;
   logic              w_s_awvalid, w_s_wvalid, w_s_arvalid, w_s_bready, w_s_rready;
   logic              w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;

   // Arbitration: a lone requester wins; on a tie the master not served last wins.
   assign w_req0   = m0_awvalid | m0_arvalid;
   assign w_req1   = m1_awvalid | m1_arvalid;
   assign w_win    = (w_req0 & w_req1) ? ~r_last_grant : w_req1;
   assign w_win_wr = w_win ? m1_awvalid : m0_awvalid;

   assign w_in_wr = (r_state == ST_WR);
   assign w_in_wb = (r_state == ST_WB);
   assign w_in_rd = (r_state == ST_RD);
   assign w_in_rr = (r_state == ST_RR);
   assign w_to_m0 = ~r_grant;
   assign w_to_m1 = r_grant;

   assign w_sel_awvalid = r_grant ? m1_awvalid : m0_awvalid;
   assign w_sel_awaddr  = r_grant ? m1_awaddr  : m0_awaddr;
   assign w_sel_awprot  = r_grant ? m1_awprot  : m0_awprot;
   assign w_sel_wvalid  = r_grant ? m1_wvalid  : m0_wvalid;
   assign w_sel_wdata   = r_grant ? m1_wdata   : m0_wdata;
   assign w_sel_wstrb   = r_grant ? m1_wstrb   : m0_wstrb;
   assign w_sel_bready  = r_grant ? m1_bready  : m0_bready;
   assign w_sel_arvalid = r_grant ? m1_arvalid : m0_arvalid;
   assign w_sel_araddr  = r_grant ? m1_araddr  : m0_araddr;
   assign w_sel_arprot  = r_grant ? m1_arprot  : m0_arprot;
   assign w_sel_rready  = r_grant ? m1_rready  : m0_rready;

   // Done flags suppress a second beat on a phase that already completed.
   assign w_s_awvalid = w_in_wr & w_sel_awvalid & ~r_aw_done;
   assign w_s_wvalid  = w_in_wr & w_sel_wvalid & ~r_w_done;
   assign w_s_bready  = w_in_wb & w_sel_bready;
   assign w_s_arvalid = w_in_rd & w_sel_arvalid;
   assign w_s_rready  = w_in_rr & w_sel_rready;

   assign w_aw_hs = w_s_awvalid & s_awready;
   assign w_w_hs  = w_s_wvalid & s_wready;
   assign w_b_hs  = s_bvalid & w_s_bready;
   assign w_ar_hs = w_s_arvalid & s_arready;
   assign w_r_hs  = s_rvalid & w_s_rready;

   assign s_awvalid = w_s_awvalid;
   assign s_awaddr  = w_sel_awaddr;
   assign s_awprot  = w_sel_awprot;
   assign s_wvalid  = w_s_wvalid;
   assign s_wdata   = w_sel_wdata;
   assign s_wstrb   = w_sel_wstrb;
   assign s_bready  = w_s_bready;
   assign s_arvalid = w_s_arvalid;
   assign s_araddr  = w_sel_araddr;
   assign s_arprot  = w_sel_arprot;
   assign s_rready  = w_s_rready;

   assign m0_awready = w_in_wr & w_to_m0 & s_awready & ~r_aw_done;
   assign m0_wready  = w_in_wr & w_to_m0 & s_wready & ~r_w_done;
   assign m0_bvalid  = w_in_wb & w_to_m0 & s_bvalid;
   assign m0_arready = w_in_rd & w_to_m0 & s_arready;
   assign m0_rvalid  = w_in_rr & w_to_m0 & s_rvalid;
   assign m0_rdata   = (w_in_rr & w_to_m0) ? s_rdata : 32'd0;

   assign m1_awready = w_in_wr & w_to_m1 & s_awready & ~r_aw_done;
   assign m1_wready  = w_in_wr & w_to_m1 & s_wready & ~r_w_done;
   assign m1_bvalid  = w_in_wb & w_to_m1 & s_bvalid;
   assign m1_arready = w_in_rd & w_to_m1 & s_arready;
   assign m1_rvalid  = w_in_rr & w_to_m1 & s_rvalid;
   assign m1_rdata   = (w_in_rr & w_to_m1) ? s_rdata : 32'd0;

   assign grant_id    = r_grant;
   assign busy        = (r_state != ST_IDLE);
   assign o_dbg_state = r_state;

   always_ff @(posedge g_clk or posedge g_reset) begin
      if (g_reset) begin
         r_state      <= ST_IDLE;
         r_grant      <= 1'b0;
         r_last_grant <= 1'b1;
         r_aw_done    <= 1'b0;
         r_w_done     <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_req0 | w_req1) begin
                  r_grant   <= w_win;
                  r_aw_done <= 1'b0;
                  r_w_done  <= 1'b0;
                  r_state   <= w_win_wr ? ST_WR : ST_RD;
               end
            end
            ST_WR: begin
               if (w_aw_hs) r_aw_done <= 1'b1;
               if (w_w_hs)  r_w_done  <= 1'b1;
               if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) r_state <= ST_WB;
            end
            ST_WB: begin
               if (w_b_hs) begin
                  r_state      <= ST_IDLE;
                  r_last_grant <= r_grant;
               end
            end
            ST_RD: begin
               if (w_ar_hs) r_state <= ST_RR;
            end
            ST_RR: begin
               if (w_r_hs) begin
                  r_state      <= ST_IDLE;
                  r_last_grant <= r_grant;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_scarv_integ_axi_arb2.sv
// Directed bench for scarv_integ_axi_arb2: the bench plays both masters and the slave and
// checks every output against hand-computed values.
module tb_scarv_integ_axi_arb2;

   localparam int ADDR_W = 32;

   logic              g_clk = 1'b0;
   logic              g_reset;

   logic              m0_awvalid, m0_awready, m0_wvalid, m0_wready, m0_bvalid, m0_bready;
   logic              m0_arvalid, m0_arready, m0_rvalid, m0_rready;
   logic [ADDR_W-1:0] m0_awaddr, m0_araddr;
   logic [2:0]        m0_awprot, m0_arprot;
   logic [31:0]       m0_wdata, m0_rdata;
   logic [3:0]        m0_wstrb;

   logic              m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_bvalid, m1_bready;
   logic              m1_arvalid, m1_arready, m1_rvalid, m1_rready;
   logic [ADDR_W-1:0] m1_awaddr, m1_araddr;
   logic [2:0]        m1_awprot, m1_arprot;
   logic [31:0]       m1_wdata, m1_rdata;
   logic [3:0]        m1_wstrb;

   logic              s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
   logic              s_arvalid, s_arready, s_rvalid, s_rready;
   logic [ADDR_W-1:0] s_awaddr, s_araddr;
   logic [2:0]        s_awprot, s_arprot;
   logic [31:0]       s_wdata, s_rdata;
   logic [3:0]        s_wstrb;

   logic              grant_id, busy;
   logic [2:0]        o_dbg_state;

   logic [0:0] exp_q[$];
   int n_vec = 0;
   int n_bad = 0;
   int aw_beats = 0;
   int w_beats = 0;
   int out_cnt = 0;
   int max_out = 0;

   scarv_integ_axi_arb2 #(.ADDR_W(ADDR_W)) dut (
      .g_clk(g_clk), .g_reset(g_reset),
      .m0_awvalid(m0_awvalid), .m0_awready(m0_awready), .m0_awaddr(m0_awaddr), .m0_awprot(m0_awprot),
      .m0_wvalid(m0_wvalid), .m0_wready(m0_wready), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
      .m0_bvalid(m0_bvalid), .m0_bready(m0_bready),
      .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr), .m0_arprot(m0_arprot),
      .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata),
      .m1_awvalid(m1_awvalid), .m1_awready(m1_awready), .m1_awaddr(m1_awaddr), .m1_awprot(m1_awprot),
      .m1_wvalid(m1_wvalid), .m1_wready(m1_wready), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
      .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
      .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr), .m1_arprot(m1_arprot),
      .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata),
      .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awprot(s_awprot),
      .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
      .s_bvalid(s_bvalid), .s_bready(s_bready),
      .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arprot(s_arprot),
      .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
      .grant_id(grant_id), .busy(busy), .o_dbg_state(o_dbg_state)
   );

   // Clock / watchdog
   always #5 g_clk = ~g_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within 200000 time units");
      $fatal(1, "watchdog");
   end

   // Slave-side monitor: beat counts and read transactions outstanding at the slave.
   always @(posedge g_clk) begin
      if (s_awvalid && s_awready) aw_beats <= aw_beats + 1;
      if (s_wvalid && s_wready)   w_beats  <= w_beats + 1;
      out_cnt <= out_cnt + ((s_arvalid && s_arready) ? 1 : 0) - ((s_rvalid && s_rready) ? 1 : 0);
      if (out_cnt + ((s_arvalid && s_arready) ? 1 : 0) - ((s_rvalid && s_rready) ? 1 : 0) > max_out)
         max_out <= out_cnt + ((s_arvalid && s_arready) ? 1 : 0) - ((s_rvalid && s_rready) ? 1 : 0);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge g_clk);
      #1;
   endtask

   // Driver tasks
   task automatic clear_inputs();
      m0_awvalid = 0; m0_awaddr = '0; m0_awprot = 3'd0; m0_wvalid = 0; m0_wdata = '0; m0_wstrb = '0;
      m0_arvalid = 0; m0_araddr = '0; m0_arprot = 3'd0; m0_bready = 1; m0_rready = 1;
      m1_awvalid = 0; m1_awaddr = '0; m1_awprot = 3'd0; m1_wvalid = 0; m1_wdata = '0; m1_wstrb = '0;
      m1_arvalid = 0; m1_araddr = '0; m1_arprot = 3'd0; m1_bready = 1; m1_rready = 1;
      s_awready = 0; s_wready = 0; s_bvalid = 0; s_arready = 0; s_rvalid = 0; s_rdata = '0;
   endtask

   task automatic drive_w(input logic m, input logic v, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s);
      if (m) begin
         m1_awvalid = v; m1_wvalid = v; m1_awaddr = a; m1_wdata = d; m1_wstrb = s;
      end else begin
         m0_awvalid = v; m0_wvalid = v; m0_awaddr = a; m0_wdata = d; m0_wstrb = s;
      end
   endtask

   task automatic drive_ar(input logic m, input logic v, input logic [31:0] a);
      if (m) begin
         m1_arvalid = v; m1_araddr = a;
      end else begin
         m0_arvalid = v; m0_araddr = a;
      end
   endtask

   function automatic logic m_bvalid(input logic m);
      return m ? m1_bvalid : m0_bvalid;
   endfunction

   function automatic logic [31:0] m_rdata(input logic m);
      return m ? m1_rdata : m0_rdata;
   endfunction

   function automatic logic [31:0] other_outs(input logic m);
      if (m) return {27'd0, m0_awready, m0_wready, m0_bvalid, m0_arready, m0_rvalid} | m0_rdata;
      else   return {27'd0, m1_awready, m1_wready, m1_bvalid, m1_arready, m1_rvalid} | m1_rdata;
   endfunction

   function automatic logic [31:0] s_handshake_outs();
      return {27'd0, s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready};
   endfunction

   // Zero-wait write from master m; it must be the sole requester.
   task automatic do_write(input logic m, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s);
      drive_w(m, 1'b1, a, d, s);
      s_awready = 1; s_wready = 1;
      #1;
      check_eq("wr_no_comb_awvalid", s_awvalid, 0);
      check_eq("wr_idle_busy", busy, 0);
      tick();
      check_eq("wr_grant", grant_id, m);
      check_eq("wr_s_valids", {s_awvalid, s_wvalid}, 2'b11);
      check_eq("wr_awaddr", s_awaddr, a);
      check_eq("wr_wdata", s_wdata, d);
      check_eq("wr_wstrb", s_wstrb, s);
      check_eq("wr_other_quiet", other_outs(m), 0);
      tick();
      drive_w(m, 1'b0, 32'd0, 32'd0, 4'd0);
      s_bvalid = 1;
      #1;
      check_eq("wr_bvalid", m_bvalid(m), 1);
      check_eq("wr_wb_busy", busy, 1);
      check_eq("wr_wb_no_valids", {s_awvalid, s_wvalid}, 0);
      check_eq("wr_wb_other_quiet", other_outs(m), 0);
      tick();
      s_bvalid = 0;
      #1;
      check_eq("wr_back_idle", busy, 0);
   endtask

   initial begin : main
      int aw0, w0, served0, served1;
      logic g;
      bit hs;

      clear_inputs();
      g_reset = 1;
      repeat (2) @(posedge g_clk);
      #1;
      check_eq("rst_busy", busy, 0);
      check_eq("rst_grant", grant_id, 0);
      check_eq("rst_s_outs", s_handshake_outs(), 0);
      check_eq("rst_m0_outs", other_outs(1'b1), 0);
      check_eq("rst_m1_outs", other_outs(1'b0), 0);
      g_reset = 0;

      // Tie after reset: m0 first, then m1
      drive_ar(1'b0, 1'b1, 32'h0000_0400);
      drive_ar(1'b1, 1'b1, 32'h0000_0800);
      s_arready = 1;
      #1;
      check_eq("tie_no_comb_arvalid", s_arvalid, 0);
      tick();
      check_eq("tie_grant0", grant_id, 0);
      check_eq("tie_araddr0", s_araddr, 32'h0000_0400);
      check_eq("tie_arready", {m0_arready, m1_arready}, 2'b10);
      tick();
      drive_ar(1'b0, 1'b0, 32'd0);
      s_rvalid = 1; s_rdata = 32'hCAFE_0001;
      #1;
      check_eq("tie_m0_rdata", m0_rdata, 32'hCAFE_0001);
      check_eq("tie_rvalid0", {m0_rvalid, m1_rvalid}, 2'b10);
      check_eq("tie_m1_rdata_zero", m1_rdata, 0);
      tick();
      s_rvalid = 0;
      #1;
      check_eq("tie_idle_gap", busy, 0);
      tick();
      check_eq("tie_grant1", grant_id, 1);
      check_eq("tie_araddr1", s_araddr, 32'h0000_0800);
      check_eq("tie_arready1", {m0_arready, m1_arready}, 2'b01);
      tick();
      drive_ar(1'b1, 1'b0, 32'd0);
      s_rvalid = 1; s_rdata = 32'h1234_5678;
      #1;
      check_eq("tie_m1_rdata", m1_rdata, 32'h1234_5678);
      check_eq("tie_m0_rdata_zero", m0_rdata, 0);
      tick();
      s_rvalid = 0; s_arready = 0;
      #1;
      check_eq("tie_done", busy, 0);

      // Single zero-wait write from m0
      do_write(1'b0, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF);

      // Split write: W accepted two cycles before AW; m1 keeps wvalid high throughout
      aw0 = aw_beats; w0 = w_beats;
      drive_w(1'b1, 1'b1, 32'h0000_2000, 32'h55AA_55AA, 4'h3);
      s_awready = 0; s_wready = 1;
      tick();
      check_eq("split_grant", grant_id, 1);
      check_eq("split_first_valids", {s_awvalid, s_wvalid}, 2'b11);
      check_eq("split_readies", {m1_awready, m1_wready}, 2'b01);
      tick();
      check_eq("split_w_dropped", {s_awvalid, s_wvalid, m1_wready}, 3'b100);
      check_eq("split_not_wb", s_bready, 0);
      tick();
      check_eq("split_still_wr", {s_wvalid, s_bready}, 2'b00);
      s_awready = 1;
      #1;
      check_eq("split_awready", m1_awready, 1);
      tick();
      drive_w(1'b1, 1'b0, 32'd0, 32'd0, 4'd0);
      s_bvalid = 1;
      #1;
      check_eq("split_bvalid", m1_bvalid, 1);
      tick();
      s_bvalid = 0;
      #1;
      check_eq("split_idle", busy, 0);
      check_eq("split_aw_beats", aw_beats - aw0, 1);
      check_eq("split_w_beats", w_beats - w0, 1);

      // Write over read from m1 in the same cycle
      drive_w(1'b1, 1'b1, 32'h0000_3000, 32'h0F0F_F0F0, 4'hF);
      drive_ar(1'b1, 1'b1, 32'h0000_4000);
      s_awready = 1; s_wready = 1; s_arready = 1;
      tick();
      check_eq("wor_grant_wr", grant_id, 1);
      check_eq("wor_write_first", {s_awvalid, s_arvalid}, 2'b10);
      tick();
      drive_w(1'b1, 1'b0, 32'd0, 32'd0, 4'd0);
      s_bvalid = 1;
      #1;
      check_eq("wor_bvalid", m1_bvalid, 1);
      check_eq("wor_no_ar_yet", s_arvalid, 0);
      tick();
      s_bvalid = 0;
      tick();
      check_eq("wor_grant_rd", grant_id, 1);
      check_eq("wor_arvalid", s_arvalid, 1);
      check_eq("wor_araddr", s_araddr, 32'h0000_4000);
      tick();
      drive_ar(1'b1, 1'b0, 32'd0);
      s_rvalid = 1; s_rdata = 32'h0BAD_F00D;
      #1;
      check_eq("wor_rdata", m1_rdata, 32'h0BAD_F00D);
      tick();
      s_rvalid = 0; s_arready = 0;
      #1;
      check_eq("wor_idle", busy, 0);

      // Reset in the middle of WB, then a fresh m0 write
      drive_w(1'b0, 1'b1, 32'h0000_5000, 32'h1111_2222, 4'hF);
      s_awready = 1; s_wready = 1;
      tick();
      tick();
      drive_w(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      s_bvalid = 1;
      #1;
      check_eq("rwb_bvalid_before", m0_bvalid, 1);
      #1;
      g_reset = 1;
      #1;
      check_eq("rwb_bvalid_cleared", m0_bvalid, 0);
      check_eq("rwb_busy_cleared", busy, 0);
      check_eq("rwb_s_outs_cleared", s_handshake_outs(), 0);
      clear_inputs();
      tick();
      g_reset = 0;
      do_write(1'b0, 32'h0000_6000, 32'hA5A5_5A5A, 4'hC);

      // Fairness: both masters keep reads pending; last grant was m0, so m1 goes first
      for (int t = 0; t < 20; t++) exp_q.push_back((t % 2 == 0) ? 1'b1 : 1'b0);
      served0 = 0; served1 = 0;
      drive_ar(1'b0, 1'b1, 32'h0000_0100);
      drive_ar(1'b1, 1'b1, 32'h0000_0200);
      for (int t = 0; t < 20; t++) begin
         hs = 0;
         g = 1'b0;
         for (int c = 0; c < 64 && !hs; c++) begin
            s_arready = 1'($urandom_range(0, 1));
            #1;
            if (s_arvalid && s_arready) begin
               hs = 1;
               g = exp_q.pop_front();
               check_eq("fair_grant", grant_id, g);
               if (grant_id) served1++; else served0++;
            end
            tick();
         end
         s_arready = 0;
         if (!hs) begin
            check_eq("fair_ar_timeout", 0, 1);
            break;
         end
         hs = 0;
         for (int c = 0; c < 64 && !hs; c++) begin
            s_rvalid = 1'($urandom_range(0, 1));
            s_rdata = 32'hA000_0000 + t;
            #1;
            if (s_rvalid && s_rready) begin
               hs = 1;
               check_eq("fair_rdata", m_rdata(g), 32'hA000_0000 + t);
               check_eq("fair_other_rdata", m_rdata(~g), 0);
            end
            tick();
         end
         s_rvalid = 0;
         if (!hs) begin
            check_eq("fair_r_timeout", 0, 1);
            break;
         end
      end
      drive_ar(1'b0, 1'b0, 32'd0);
      drive_ar(1'b1, 1'b0, 32'd0);
      tick();
      check_eq("fair_served0", served0, 10);
      check_eq("fair_served1", served1, 10);
      check_eq("fair_queue_drained", exp_q.size(), 0);
      check_eq("fair_max_outstanding", max_out, 1);
      check_eq("fair_end_idle", busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
